lcd_bus_monitor: RTL and testbench

Passive receiver for the HD44780-style 4-bit LCD bus driven by `text_lcd_ctrl`: samples `lcd_en`/`lcd_rs`/`lcd_rw`/`lcd_data` from the pins. It tracks 8-bit/4-bit mode, reassembles bytes and decodes commands. It maintains a 2x16 shadow of the visible DDRAM, which a bench or on-chip checker reads back. It sits beside the LCD pins in loopback and self-check builds and never drives the bus.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_bus_monitor_if.sv | 10 +
 rtl/lcd_bus_sync.sv | 65 ++++++
 rtl/lcd_bus_monitor.sv | 199 +++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, opcode masks and address helpers for the HD44780-style bus monitor.
package lcd_pkg;

  localparam logic [7:0] SETDDRAM_MASK = 8'h80, SETDDRAM_VAL = 8'h80;
  localparam logic [7:0] FUNCSET_MASK  = 8'hE0, FUNCSET_VAL  = 8'h20;
  localparam logic [7:0] DISPCTL_MASK  = 8'hF8, DISPCTL_VAL  = 8'h08;
  localparam logic [7:0] ENTRY_MASK    = 8'hFC, ENTRY_VAL    = 8'h04;
  localparam logic [7:0] HOME_MASK     = 8'hFE, HOME_VAL     = 8'h02;
  localparam logic [7:0] CLEAR_MASK    = 8'hFF, CLEAR_VAL    = 8'h01;
  localparam int unsigned FUNCSET_DL_BIT = 4;

  localparam logic [6:0] VIS0_LO = 7'h00, VIS0_HI = 7'h0F;
  localparam logic [6:0] VIS1_LO = 7'h40, VIS1_HI = 7'h4F;
  localparam logic [6:0] WRAP0   = 7'h27, WRAP1   = 7'h67;

  localparam logic [7:0]  BLANK_CHAR   = 8'h20;
  localparam int unsigned LINE_LEN     = 16;
  localparam int unsigned SHADOW_DEPTH = 2 * LINE_LEN;

  typedef enum logic {PH_HIGH, PH_LOW} nib_phase_t;

  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] mask,
                                  input logic [7:0] val);
    return (b & mask) == val;
  endfunction

  function automatic logic is_visible(input logic [6:0] a);
    return (a >= VIS0_LO && a <= VIS0_HI) || (a >= VIS1_LO && a <= VIS1_HI);
  endfunction

  function automatic logic [4:0] shadow_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // DDRAM counter only spans 0x00-0x27 and 0x40-0x67, wrapping between the two lines
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == WRAP0) return VIS1_LO;
      if (a == WRAP1) return VIS0_LO;
      return a + 7'd1;
    end
    if (a == VIS1_LO) return WRAP0;
    if (a == VIS0_LO) return WRAP1;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_monitor_if.sv
// LCD pin bundle: the controller drives it (master), the monitor only observes (slave).
interface lcd_bus_monitor_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_data;

  modport master (output lcd_en, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input  lcd_en, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizer and lcd_en falling-edge detector; hold check built with LCD_BUS_MONITOR_HOLD_CHECK_EN.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_in,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [3:0] data_in,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [3:0] nib
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
  , output logic     hold_viol
`endif
);

  logic [SYNC_STAGES-1:0] en_sr, rs_sr, rw_sr;
  logic [3:0]             data_sr [SYNC_STAGES];
  logic                   en_last, rs_last, rw_last;
  logic [3:0]             data_last;

  // *_last holds the sample that accompanied the final en=1, so bus fields line up with the fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sr     <= '0;
      rs_sr     <= '0;
      rw_sr     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
      en_last   <= 1'b0;
      rs_last   <= 1'b0;
      rw_last   <= 1'b0;
      data_last <= '0;
      strobe    <= 1'b0;
      rs        <= 1'b0;
      rw        <= 1'b0;
      nib       <= '0;
    end else begin
      en_sr      <= {en_sr[SYNC_STAGES-2:0], en_in};
      rs_sr      <= {rs_sr[SYNC_STAGES-2:0], rs_in};
      rw_sr      <= {rw_sr[SYNC_STAGES-2:0], rw_in};
      data_sr[0] <= data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
      en_last    <= en_sr[SYNC_STAGES-1];
      rs_last    <= rs_sr[SYNC_STAGES-1];
      rw_last    <= rw_sr[SYNC_STAGES-1];
      data_last  <= data_sr[SYNC_STAGES-1];
      strobe     <= en_last & ~en_sr[SYNC_STAGES-1];
      rs         <= rs_last;
      rw         <= rw_last;
      nib        <= data_last;
    end
  end

`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_viol <= 1'b0;
    else hold_viol <= en_sr[SYNC_STAGES-1] & en_last &
                      ((data_sr[SYNC_STAGES-1] != data_last) | (rs_sr[SYNC_STAGES-1] != rs_last));
  end
`endif

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 4-bit bus monitor with a 2x16 DDRAM shadow.
// Optional hold/rs-consistency checking: define LCD_BUS_MONITOR_HOLD_CHECK_EN.
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_bus_monitor_if.slave   lcd,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_is_cmd,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_char,
  output logic [6:0]         cursor_addr,
  output logic               mode_4bit,
  output logic               display_on,
  output logic               busy,
  output logic [2:0]         err
);

  logic       strobe, s_rs, s_rw;
  logic [3:0] s_nib;
  nib_phase_t phase_q, phase_d;
  logic       mode_d, latch_hi, form_valid, form_rs, entry_inc;
  logic [3:0] hi_nib;
  logic [7:0] form_byte, pend_byte, exec_byte, wr_data;
  logic       pend_full, pend_rs, pend_fire, form_now, to_pend, drop;
  logic       fill_start_q, fill_active, exec_v, exec_rs, wr_en;
  logic [4:0] fill_idx, wr_idx;
  logic [1:0] err_q;
  logic [7:0] shadow [SHADOW_DEPTH];
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
  logic       hold_viol, hi_rs, mix, err2_q;
`endif

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .en_in   (lcd.lcd_en),
    .rs_in   (lcd.lcd_rs),
    .rw_in   (lcd.lcd_rw),
    .data_in (lcd.lcd_data),
    .strobe  (strobe),
    .rs      (s_rs),
    .rw      (s_rw),
    .nib     (s_nib)
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
    , .hold_viol (hold_viol)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_HIGH;
    else          phase_q <= phase_d;
  end

  always_comb begin
    phase_d    = phase_q;
    mode_d     = mode_4bit;
    latch_hi   = 1'b0;
    form_valid = 1'b0;
    form_rs    = s_rs;
    form_byte  = '0;
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
    mix        = 1'b0;
`endif
    if (strobe && !s_rw) begin
      if (!mode_4bit) begin
        form_valid = 1'b1;
        form_byte  = {s_nib, 4'h0};
        if (!s_rs && is_cmd(form_byte, FUNCSET_MASK, FUNCSET_VAL) && !form_byte[FUNCSET_DL_BIT]) begin
          mode_d  = 1'b1;
          phase_d = PH_HIGH;
        end
      end else begin
        case (phase_q)
          PH_HIGH: begin
            latch_hi = 1'b1;
            phase_d  = PH_LOW;
          end
          default: begin
            form_valid = 1'b1;
            form_byte  = {hi_nib, s_nib};
            phase_d    = PH_HIGH;
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
            mix        = hi_rs != s_rs;
`endif
            if (!s_rs && is_cmd(form_byte, FUNCSET_MASK, FUNCSET_VAL) && form_byte[FUNCSET_DL_BIT])
              mode_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Mode/phase track the bus immediately; only command/data execution waits behind the fill
  always_comb begin
    fill_active = busy | fill_start_q;
    pend_fire   = pend_full & ~fill_active;
    form_now    = form_valid & ~fill_active & ~pend_full;
    to_pend     = form_valid & ~form_now & (~pend_full | pend_fire);
    drop        = form_valid & pend_full & ~pend_fire;
    exec_v      = pend_fire | form_now;
    exec_byte   = pend_fire ? pend_byte : form_byte;
    exec_rs     = pend_fire ? pend_rs : form_rs;
    wr_en       = busy | (exec_v & exec_rs & is_visible(cursor_addr));
    wr_idx      = busy ? fill_idx : shadow_index(cursor_addr);
    wr_data     = busy ? BLANK_CHAR : exec_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_cmd  <= 1'b0;
      mode_4bit    <= 1'b0;
      hi_nib       <= '0;
      pend_full    <= 1'b0;
      pend_rs      <= 1'b0;
      pend_byte    <= '0;
      fill_start_q <= 1'b1;
      fill_idx     <= '0;
      busy         <= 1'b0;
      cursor_addr  <= '0;
      display_on   <= 1'b0;
      entry_inc    <= 1'b1;
      err_q        <= '0;
    end else begin
      byte_valid <= form_valid;
      if (form_valid) begin
        byte_data   <= form_byte;
        byte_is_cmd <= ~form_rs;
      end
      mode_4bit <= mode_d;
      if (latch_hi) hi_nib <= s_nib;
      if (strobe && s_rw) err_q[0] <= 1'b1;
      if (drop) err_q[1] <= 1'b1;

      if (to_pend) begin
        pend_full <= 1'b1;
        pend_byte <= form_byte;
        pend_rs   <= form_rs;
      end else if (pend_fire) begin
        pend_full <= 1'b0;
      end

      if (fill_start_q) begin
        fill_start_q <= 1'b0;
        busy         <= 1'b1;
        fill_idx     <= '0;
      end else if (busy) begin
        fill_idx <= fill_idx + 5'd1;
        if (fill_idx == 5'(SHADOW_DEPTH - 1)) busy <= 1'b0;
      end else if (exec_v && !exec_rs && is_cmd(exec_byte, CLEAR_MASK, CLEAR_VAL)) begin
        busy     <= 1'b1;
        fill_idx <= '0;
      end

      if (exec_v) begin
        if (exec_rs) cursor_addr <= next_addr(cursor_addr, entry_inc);
        else if (is_cmd(exec_byte, SETDDRAM_MASK, SETDDRAM_VAL)) cursor_addr <= exec_byte[6:0];
        else if (is_cmd(exec_byte, DISPCTL_MASK, DISPCTL_VAL)) display_on <= exec_byte[2];
        else if (is_cmd(exec_byte, ENTRY_MASK, ENTRY_VAL)) entry_inc <= exec_byte[1];
        else if (is_cmd(exec_byte, HOME_MASK, HOME_VAL)) cursor_addr <= '0;
        else if (is_cmd(exec_byte, CLEAR_MASK, CLEAR_VAL)) begin
          cursor_addr <= '0;
          entry_inc   <= 1'b1;
        end
      end
    end
  end

`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_rs  <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      if (latch_hi) hi_rs <= s_rs;
      if (hold_viol || (form_valid && mix)) err2_q <= 1'b1;
    end
  end
  assign err = {err2_q, err_q};
`else
  assign err = {1'b0, err_q};
`endif

  always_ff @(posedge clk) begin
    if (wr_en) shadow[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_char <= BLANK_CHAR;
    else          rd_char <= shadow[rd_addr];
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed self-checking bench for lcd_bus_monitor (default SYNC_STAGES=2).
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_valid, byte_is_cmd, mode_4bit, display_on, busy;
  logic [7:0] byte_data, rd_char;
  logic [4:0] rd_addr = '0;
  logic [6:0] cursor_addr;
  logic [2:0] err;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt = 0;

  logic       bv_hit, bv_extra, bv_cmd;
  logic [7:0] bv_byte;

  always #5 clk = ~clk;

  lcd_bus_monitor_if lcd_bus ();

  lcd_bus_monitor #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .lcd         (lcd_bus),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_is_cmd (byte_is_cmd),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .mode_4bit   (mode_4bit),
    .display_on  (display_on),
    .busy        (busy),
    .err         (err)
  );

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  // One strobe: en high 2 cycles, then 4 cycles of hold; byte_valid expected on the 4th cycle after the fall
  task automatic drive_nib(input logic rs, input logic rw, input logic [3:0] nib);
    @(negedge clk);
    lcd_bus.lcd_rs = rs; lcd_bus.lcd_rw = rw; lcd_bus.lcd_data = nib; lcd_bus.lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    lcd_bus.lcd_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bv_hit = byte_valid; bv_byte = byte_data; bv_cmd = byte_is_cmd;
      end else if (byte_valid) bv_extra = 1'b1;
    end
  endtask

  task automatic drive_byte(input logic rs, input logic [7:0] b);
    logic spur;
    drive_nib(rs, 1'b0, b[7:4]);
    spur = bv_hit;
    drive_nib(rs, 1'b0, b[3:0]);
    if (spur) bv_extra = 1'b1;
  endtask

  task automatic read_check(input int idx, input logic [7:0] exp);
    @(negedge clk) rd_addr = 5'(idx);
    @(negedge clk);
    tests_run++;
    if (rd_char !== exp) begin
      tests_failed++;
      $display("FAIL shadow[%0d]: got %h expected %h", idx, rd_char, exp);
    end
  endtask

  task automatic wait_fill_done(input string tag);
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_busy_timeout: got %b expected 0", tag, busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    lcd_bus.lcd_en = 1'b0; lcd_bus.lcd_rs = 1'b0; lcd_bus.lcd_rw = 1'b0; lcd_bus.lcd_data = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({byte_valid, byte_data, byte_is_cmd, rd_char} !== {1'b0, 8'h00, 1'b0, 8'h20}) begin
      tests_failed++;
      $display("FAIL reset_bytes: got %b %h %b %h expected 0 00 0 20", byte_valid, byte_data, byte_is_cmd, rd_char);
    end
    tests_run++;
    if ({cursor_addr, mode_4bit, display_on, busy, err} !== {7'h00, 1'b0, 1'b0, 1'b0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_state: got %h %b %b %b %b expected 00 0 0 0 000", cursor_addr, mode_4bit, display_on, busy, err);
    end
    busy_cnt = 0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    wait_fill_done("reset");
    tests_run++;
    if (busy_cnt != 32) begin
      tests_failed++;
      $display("FAIL reset_fill_len: got %0d expected 32", busy_cnt);
    end
    for (int i = 0; i < 32; i += 5) read_check(i, 8'h20);
    read_check(31, 8'h20);
  endtask

  task automatic test_init_seq;
    logic [3:0] nibs [4];
    logic [7:0] exp  [4];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    exp  = '{8'h30, 8'h30, 8'h30, 8'h20};
    bv_extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_nib(1'b0, 1'b0, nibs[i]);
      tests_run++;
      if ({bv_hit, bv_byte, bv_cmd} !== {1'b1, exp[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL init_byte%0d: got %b %h %b expected 1 %h 1", i, bv_hit, bv_byte, bv_cmd, exp[i]);
      end
      tests_run++;
      if (mode_4bit !== (i == 3)) begin
        tests_failed++;
        $display("FAIL init_mode%0d: got %b expected %b", i, mode_4bit, (i == 3));
      end
    end
    tests_run++;
    if (bv_extra !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_bv_timing: got early pulse %b expected 0", bv_extra);
    end
  endtask

  task automatic test_line0;
    string s = "BIDIR MORSE TEST";
    bv_extra = 1'b0;
    drive_byte(1'b0, 8'h0C);
    tests_run++;
    if ({bv_hit, bv_byte, bv_cmd, display_on} !== {1'b1, 8'h0C, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL dispctl: got %b %h %b %b expected 1 0c 1 1", bv_hit, bv_byte, bv_cmd, display_on);
    end
    drive_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) drive_byte(1'b1, s[i]);
    tests_run++;
    if ({bv_hit, bv_byte, bv_cmd, bv_extra} !== {1'b1, 8'h54, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL line0_last_byte: got %b %h %b %b expected 1 54 0 0", bv_hit, bv_byte, bv_cmd, bv_extra);
    end
    tests_run++;
    if (cursor_addr !== 7'h10) begin
      tests_failed++;
      $display("FAIL line0_cursor: got %h expected 10", cursor_addr);
    end
    for (int i = 0; i < 16; i++) read_check(i, s[i]);
  endtask

  task automatic test_line1;
    string s = "0123456789abcdef";
    drive_byte(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) drive_byte(1'b1, s[i]);
    tests_run++;
    if (cursor_addr !== 7'h50) begin
      tests_failed++;
      $display("FAIL line1_cursor: got %h expected 50", cursor_addr);
    end
    for (int i = 0; i < 16; i++) read_check(16 + i, s[i]);
    read_check(0, 8'h42);
  endtask

  task automatic test_wrap;
    drive_byte(1'b0, 8'hA7);
    drive_byte(1'b1, 8'h41);
    tests_run++;
    if (cursor_addr !== 7'h40) begin
      tests_failed++;
      $display("FAIL wrap_inc_cursor: got %h expected 40", cursor_addr);
    end
    read_check(16, 8'h30);
    drive_byte(1'b1, 8'h42);
    read_check(16, 8'h42);
    tests_run++;
    if (cursor_addr !== 7'h41) begin
      tests_failed++;
      $display("FAIL wrap_after_b: got %h expected 41", cursor_addr);
    end
    drive_byte(1'b0, 8'h04);
    drive_byte(1'b0, 8'hC0);
    drive_byte(1'b1, 8'h43);
    tests_run++;
    if (cursor_addr !== 7'h27) begin
      tests_failed++;
      $display("FAIL wrap_dec_40: got %h expected 27", cursor_addr);
    end
    read_check(16, 8'h43);
    drive_byte(1'b0, 8'h80);
    drive_byte(1'b1, 8'h45);
    tests_run++;
    if (cursor_addr !== 7'h67) begin
      tests_failed++;
      $display("FAIL wrap_dec_00: got %h expected 67", cursor_addr);
    end
    read_check(0, 8'h45);
    drive_byte(1'b0, 8'h06);
    drive_byte(1'b0, 8'h02);
    tests_run++;
    if (cursor_addr !== 7'h00) begin
      tests_failed++;
      $display("FAIL home_cursor: got %h expected 00", cursor_addr);
    end
  endtask

  task automatic test_clear_fill;
    busy_cnt = 0;
    drive_byte(1'b0, 8'h01);
    tests_run++;
    if ({bv_hit, busy, cursor_addr} !== {1'b1, 1'b1, 7'h00}) begin
      tests_failed++;
      $display("FAIL clear_start: got %b %b %h expected 1 1 00", bv_hit, busy, cursor_addr);
    end
    drive_byte(1'b1, 8'h58);
    tests_run++;
    if ({bv_hit, bv_byte, busy, err[1]} !== {1'b1, 8'h58, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL fill_pending: got %b %h %b %b expected 1 58 1 0", bv_hit, bv_byte, busy, err[1]);
    end
    drive_byte(1'b1, 8'h59);
    tests_run++;
    if ({bv_hit, busy, err[1]} !== {1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL fill_overflow: got %b %b %b expected 1 1 1", bv_hit, busy, err[1]);
    end
    wait_fill_done("clear");
    tests_run++;
    if (busy_cnt != 32) begin
      tests_failed++;
      $display("FAIL clear_fill_len: got %0d expected 32", busy_cnt);
    end
    tests_run++;
    if (cursor_addr !== 7'h01) begin
      tests_failed++;
      $display("FAIL clear_cursor: got %h expected 01", cursor_addr);
    end
    read_check(0, 8'h58);
    for (int i = 1; i < 32; i++) read_check(i, 8'h20);
  endtask

  task automatic test_rw_and_reset;
    bv_extra = 1'b0;
    drive_nib(1'b0, 1'b1, 4'h8);
    tests_run++;
    if ({bv_hit, bv_extra, err[0]} !== {1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rw_strobe: got %b %b %b expected 0 0 1", bv_hit, bv_extra, err[0]);
    end
    drive_nib(1'b1, 1'b0, 4'h5);
    tests_run++;
    if ({bv_hit, mode_4bit} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL high_nibble: got %b %b expected 0 1", bv_hit, mode_4bit);
    end
    @(negedge clk);
    busy_cnt = 0;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({mode_4bit, err, busy} !== {1'b0, 3'b000, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got %b %b %b expected 0 000 0", mode_4bit, err, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    wait_fill_done("rst2");
    tests_run++;
    if (busy_cnt != 32) begin
      tests_failed++;
      $display("FAIL refill_len: got %0d expected 32", busy_cnt);
    end
    read_check(0, 8'h20);
    read_check(16, 8'h20);
    drive_nib(1'b0, 1'b0, 4'h3);
    tests_run++;
    if ({bv_hit, bv_byte, mode_4bit} !== {1'b1, 8'h30, 1'b0}) begin
      tests_failed++;
      $display("FAIL post_reset_8bit: got %b %h %b expected 1 30 0", bv_hit, bv_byte, mode_4bit);
    end
  endtask

  task automatic test_hold;
    logic exp2;
`ifdef LCD_BUS_MONITOR_HOLD_CHECK_EN
    exp2 = 1'b1;
`else
    exp2 = 1'b0;
`endif
    @(negedge clk);
    lcd_bus.lcd_rs = 1'b0; lcd_bus.lcd_rw = 1'b0; lcd_bus.lcd_data = 4'h0; lcd_bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_bus.lcd_data = 4'h3;
    repeat (4) @(negedge clk);
    lcd_bus.lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if ({err[2], byte_data} !== {exp2, 8'h30}) begin
      tests_failed++;
      $display("FAIL hold_check: got %b %h expected %b 30", err[2], byte_data, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_line0();
    test_line1();
    test_wrap();
    test_clear_fill();
    test_rw_and_reset();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
